// File: rtl/aoc_pkg.sv
// Shared definitions for the dial-command parser and lock_over_zero:
// rotation direction, default data width, ASCII codes and parser states.
package aoc_pkg;

  localparam int DATA_WIDTH = 24;

  typedef enum logic {
    RIGHT = 1'b0,
    LEFT  = 1'b1
  } dir_t;

  localparam logic [7:0] ASCII_L  = 8'h4C;
  localparam logic [7:0] ASCII_R  = 8'h52;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_9  = 8'h39;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIGITS = 2'd1,
    SKIP   = 2'd2,
    DONE   = 2'd3
  } parser_state_t;

endpackage

// File: rtl/dec_accum.sv
// Decimal accumulator step: result = acc*10 + digit, saturated to all-ones.
// The multiply is done as two shifts and an add in a 4-bit-wider field so
// the overflow is visible in the upper bits; no multiplier or divider.
module dec_accum #(
  parameter int DATA_WIDTH = aoc_pkg::DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] acc,
  input  logic [3:0]            digit,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  overflow
);

  logic [DATA_WIDTH+3:0] wide;

  // Widen, multiply by ten, add digit, then clamp on overflow.
  always_comb begin
    wide     = ({4'd0, acc} << 3) + ({4'd0, acc} << 1) + {{DATA_WIDTH{1'b0}}, digit};
    overflow = |wide[DATA_WIDTH+3:DATA_WIDTH];
    if (overflow) begin
      result = {DATA_WIDTH{1'b1}};
    end else begin
      result = wide[DATA_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/rotation_cmd_parser.sv
// Converts an ASCII stream of dial commands ("L68\n", "R14\n", ...) into
// (cmd_dir, cmd_rot, cmd_en) strobes for the dial counter.
// Optional build macro AOC_PARSE_ERR_EN: counts malformed lines in err_count
// (saturating) and warns in simulation; otherwise err_count is tied to 0.
module rotation_cmd_parser
  import aoc_pkg::*;
#(
  parameter int DATA_WIDTH = aoc_pkg::DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  input  logic                  stream_end,
  output logic                  cmd_en,
  output logic                  cmd_dir,
  output logic [DATA_WIDTH-1:0] cmd_rot,
  output logic [DATA_WIDTH-1:0] cmd_count,
  output logic                  done,
  output logic [15:0]           err_count
);

  parser_state_t         state, state_next;
  dir_t                  dir_r, dir_next;
  logic [DATA_WIDTH-1:0] acc, acc_next;
  logic                  have_digit, have_next;
  logic                  eof_pending, eof_next;
  logic                  done_next;
  logic                  emit;
  logic                  malformed;
  logic                  accept;
  logic                  take_eof;
  logic                  is_digit;
  logic [7:0]            digit_off;
  logic [DATA_WIDTH-1:0] acc_step;
  logic                  acc_ovf;

  assign accept    = byte_valid && byte_ready;
  assign take_eof  = eof_pending || (stream_end && !accept);
  assign is_digit  = (byte_data >= ASCII_0) && (byte_data <= ASCII_9);
  assign digit_off = byte_data - ASCII_0;

  dec_accum #(.DATA_WIDTH(DATA_WIDTH)) u_dec_accum (
    .acc      (acc),
    .digit    (digit_off[3:0]),
    .result   (acc_step),
    .overflow (acc_ovf)
  );

  // State and line-datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      dir_r       <= RIGHT;
      acc         <= '0;
      have_digit  <= 1'b0;
      eof_pending <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_next;
      dir_r       <= dir_next;
      acc         <= acc_next;
      have_digit  <= have_next;
      eof_pending <= eof_next;
      done        <= done_next;
    end
  end

  // Next-state logic: end-of-stream handling takes priority over bytes.
  always_comb begin
    state_next = state;
    dir_next   = dir_r;
    acc_next   = acc;
    have_next  = have_digit;
    eof_next   = eof_pending;
    done_next  = done;
    emit       = 1'b0;
    malformed  = 1'b0;
    if (state == DONE) begin
      eof_next = 1'b0;
    end else if (take_eof) begin
      eof_next   = 1'b0;
      done_next  = 1'b1;
      state_next = DONE;
      if (state == DIGITS) begin
        if (have_digit) begin
          emit = 1'b1;
        end else begin
          malformed = 1'b1;
        end
      end else begin
        emit = 1'b0;
      end
    end else if (accept) begin
      eof_next = stream_end;
      if (byte_data == ASCII_CR) begin
        state_next = state;
      end else begin
        case (state)
          IDLE: begin
            if (byte_data == ASCII_L || byte_data == ASCII_R) begin
              dir_next   = (byte_data == ASCII_L) ? LEFT : RIGHT;
              acc_next   = '0;
              have_next  = 1'b0;
              state_next = DIGITS;
            end else if (byte_data == ASCII_LF) begin
              state_next = IDLE;
            end else begin
              malformed  = 1'b1;
              state_next = SKIP;
            end
          end
          DIGITS: begin
            if (is_digit) begin
              acc_next  = acc_step;
              have_next = 1'b1;
            end else begin
              emit       = have_digit;
              malformed  = !have_digit;
              state_next = (byte_data == ASCII_LF) ? IDLE : SKIP;
            end
          end
          SKIP: begin
            if (byte_data == ASCII_LF) begin
              state_next = IDLE;
            end else begin
              state_next = SKIP;
            end
          end
          default: begin
            state_next = state;
          end
        endcase
      end
    end else begin
      state_next = state;
    end
  end

  // Handshake output: stall while finished or while a deferred end is pending.
  always_comb begin
    byte_ready = !done && !eof_pending;
  end

  // Registered command outputs, one cycle after the terminating byte.
  always_ff @(posedge clock) begin
    if (reset) begin
      cmd_en    <= 1'b0;
      cmd_dir   <= RIGHT;
      cmd_rot   <= '0;
      cmd_count <= '0;
    end else begin
      cmd_en <= emit;
      if (emit) begin
        cmd_dir   <= dir_r;
        cmd_rot   <= acc;
        cmd_count <= cmd_count + {{(DATA_WIDTH-1){1'b0}}, 1'b1};
      end else begin
        cmd_count <= cmd_count;
      end
    end
  end

`ifdef AOC_PARSE_ERR_EN
  // Saturating malformed-line counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      err_count <= 16'd0;
    end else if (malformed) begin
      if (err_count != 16'hFFFF) begin
        err_count <= err_count + 16'd1;
      end else begin
        err_count <= err_count;
      end
      $warning("rotation_cmd_parser: malformed line dropped");
    end else begin
      err_count <= err_count;
    end
  end
`else
  assign err_count = 16'd0;
  logic unused_ovf;
  assign unused_ovf = acc_ovf ^ malformed;
`endif

`ifdef AOC_PARSE_ERR_EN
  logic unused_ovf;
  assign unused_ovf = acc_ovf;
`endif

endmodule

// File: tb/tb_rotation_cmd_parser.sv
// Scoreboard bench for rotation_cmd_parser: directed byte streams push the
// expected commands into a queue; a monitor pops and compares on cmd_en.
module tb_rotation_cmd_parser;

  localparam int W = 24;

  logic         clock;
  logic         reset;
  logic         byte_valid;
  logic [7:0]   byte_data;
  logic         byte_ready;
  logic         stream_end;
  logic         cmd_en;
  logic         cmd_dir;
  logic [W-1:0] cmd_rot;
  logic [W-1:0] cmd_count;
  logic         done;
  logic [15:0]  err_count;

  int checks = 0;
  int errors = 0;
  int stalls = 0;

  typedef struct {
    logic         dir;
    logic [W-1:0] rot;
    logic [W-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  rotation_cmd_parser #(.DATA_WIDTH(W)) dut (
    .clock      (clock),
    .reset      (reset),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .stream_end (stream_end),
    .cmd_en     (cmd_en),
    .cmd_dir    (cmd_dir),
    .cmd_rot    (cmd_rot),
    .cmd_count  (cmd_count),
    .done       (done),
    .err_count  (err_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor: every cmd_en pulse must match the head of the scoreboard.
  always @(negedge clock) begin
    if (cmd_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_cmd actual dir=%0d rot=%0d required none", cmd_dir, cmd_rot);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("cmd_dir", cmd_dir, e.dir);
        check("cmd_rot", cmd_rot, e.rot);
        check("cmd_count", cmd_count, e.cnt);
      end
    end
  end

  task automatic push(input logic d, input int r, input int c);
    exp_t e;
    e.dir = d;
    e.rot = W'(r);
    e.cnt = W'(c);
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    stream_end = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  // Present one byte; holds byte_valid afterwards so streams stay back-to-back.
  task automatic send(input logic [7:0] b, input logic eof);
    int n;
    byte_valid = 1'b1;
    byte_data  = b;
    stream_end = eof;
    n = 0;
    while (!byte_ready && n < 20) begin
      @(posedge clock);
      #1;
      n++;
      stalls++;
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $display("FAIL byte_ready_timeout actual=0 required=1");
    end
    @(posedge clock);
    #1;
    stream_end = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i], 1'b0);
  endtask

  task automatic end_stream();
    byte_valid = 1'b0;
    stream_end = 1'b1;
    @(posedge clock);
    #1 stream_end = 1'b0;
  endtask

  task automatic finish_check(input string tag, input int cnt, input int errs);
    repeat (3) @(posedge clock);
    #1;
    check({tag, "_done"}, done, 1);
    check({tag, "_ready"}, byte_ready, 0);
    check({tag, "_count"}, cmd_count, cnt);
    check({tag, "_err"}, err_count, errs);
    check({tag, "_pending"}, exp_q.size(), 0);
  endtask

  initial begin
    int exp_err;
    do_reset();
    check("rst_cmd_en", cmd_en, 0);
    check("rst_cmd_dir", cmd_dir, 0);
    check("rst_cmd_rot", cmd_rot, 0);
    check("rst_cmd_count", cmd_count, 0);
    check("rst_done", done, 0);
    check("rst_err", err_count, 0);
    check("rst_ready", byte_ready, 1);

    // Three commands then end of stream.
    push(1'b1, 68, 1);
    push(1'b1, 30, 2);
    push(1'b0, 48, 3);
    send_str("L68\nL30\nR48\n");
    end_stream();
    finish_check("t1", 3, 0);

    // End of stream on the same cycle as the final digit.
    do_reset();
    push(1'b0, 1000, 1);
    send_str("R100");
    send(8'h30, 1'b1);
    byte_valid = 1'b0;
    check("t2_eof_ready", byte_ready, 0);
    check("t2_eof_done", done, 0);
    @(posedge clock);
    #1;
    check("t2_done_next", done, 1);
    finish_check("t2", 1, 0);

    // Malformed lines and carriage returns.
    do_reset();
    push(1'b0, 5, 1);
    send_str("\r\nX12\nL\nR5 junk\n");
    end_stream();
`ifdef AOC_PARSE_ERR_EN
    exp_err = 2;
`else
    exp_err = 0;
`endif
    finish_check("t3", 1, exp_err);

    // Saturation at 2^24-1.
    do_reset();
    push(1'b1, 16777215, 1);
    send_str("L99999999\n");
    end_stream();
    finish_check("t4", 1, 0);

    // Continuous valid: never stalled.
    do_reset();
    push(1'b1, 1, 1);
    push(1'b0, 2, 2);
    stalls = 0;
    send_str("L1\nR2\n");
    check("t5_stalls", stalls, 0);
    end_stream();
    finish_check("t5", 2, 0);

    // Reset mid-line discards the partial command.
    do_reset();
    send_str("L12");
    do_reset();
    push(1'b0, 3, 1);
    send_str("R3\n");
    end_stream();
    finish_check("t6", 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
